alu_issue: RTL and testbench

- Issue/execute front end for the RV32I integer ALU: the producer side of the ALU's data1_in/data2_in/select_alu interface and the consumer of its data_out/zero.
- Accepts decoded-stage inputs (instruction, pc, register-file operands) over a valid/ready handshake.
- Decodes OP, OP-IMM, LUI and AUIPC into an ALU select code and operands, drives the external combinational ALU, and registers the result with rd for writeback.
- Two-stage elastic pipeline (issue register, result register) with full backpressure.

---
 rtl/alu_pkg.sv | 57 +++++
 rtl/alu_decode.sv | 98 +++++++++
 rtl/alu_issue.sv | 145 ++++++++++++++
 tb/tb_alu_issue.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the RV32I integer ALU and its issue front end.
// Holds ALU select codes, major opcodes, funct3/funct7 values and a funct3-to-select helper.
// Purely declarative: no latency, no flow control.
package alu_pkg;

    localparam int WIDTH_DATA = 32;

    typedef enum logic [3:0] {
        ALU_NOP   = 4'b0000,
        ALU_ADD   = 4'b0001,
        ALU_SUB   = 4'b0010,
        ALU_SLL   = 4'b0011,
        ALU_SLT   = 4'b0100,
        ALU_SLTU  = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_XOR   = 4'b1000,
        ALU_OR    = 4'b1001,
        ALU_AND   = 4'b1010,
        ALU_LUI   = 4'b1011,
        ALU_AUIPC = 4'b1100
    } alu_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Base-encoding operation for a funct3 (funct7 = 0000000 form).
    function automatic alu_sel_e f3_base_sel(input logic [2:0] f3);
        alu_sel_e sel;
        case (f3)
            F3_ADD_SUB: sel = ALU_ADD;
            F3_SLL:     sel = ALU_SLL;
            F3_SLT:     sel = ALU_SLT;
            F3_SLTU:    sel = ALU_SLTU;
            F3_XOR:     sel = ALU_XOR;
            F3_SRL_SRA: sel = ALU_SRL;
            F3_OR:      sel = ALU_OR;
            default:    sel = ALU_AND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of OP / OP-IMM / LUI / AUIPC into ALU select, operands, rd and illegal flag.
// Ports: instr_i, pc_i, rs1_i, rs2_i in; sel_o, data1_o, data2_o, rd_o, illegal_o out. Latency 0.
// No flow control; the caller registers the outputs.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output alu_sel_e    sel_o,
    output logic [31:0] data1_o,
    output logic [31:0] data2_o,
    output logic [4:0]  rd_o,
    output logic        illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_u  = {instr_i[31:12], 12'b0};
    assign shamt  = {27'b0, instr_i[24:20]};
    // rd is passed through for every opcode, illegal ones included.
    assign rd_o   = instr_i[11:7];

    alu_sel_e    sel;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        ill;

    always_comb begin
        sel = ALU_NOP;
        d1  = '0;
        d2  = '0;
        ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                d1 = rs1_i;
                d2 = rs2_i;
                if (funct7 == F7_BASE)
                    sel = f3_base_sel(funct3);
                else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB)
                    sel = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA)
                    sel = ALU_SRA;
                else
                    ill = 1'b1;
            end
            OPC_OP_IMM: begin
                d1 = rs1_i;
                d2 = imm_i;
                if (funct3 == F3_SLL) begin
                    d2 = shamt;
                    if (funct7 == F7_BASE) sel = ALU_SLL;
                    else                   ill = 1'b1;
                end else if (funct3 == F3_SRL_SRA) begin
                    d2 = shamt;
                    if (funct7 == F7_BASE)     sel = ALU_SRL;
                    else if (funct7 == F7_ALT) sel = ALU_SRA;
                    else                       ill = 1'b1;
                end else begin
                    // Upper immediate bits are operand, not funct7, here.
                    sel = f3_base_sel(funct3);
                end
            end
            OPC_LUI: begin
                d2  = imm_u;
                sel = ALU_LUI;
            end
            OPC_AUIPC: begin
                d1  = pc_i;
                d2  = imm_u;
                sel = ALU_AUIPC;
            end
            default: ill = 1'b1;
        endcase
        // Unsupported encodings present a quiet NOP to the ALU.
        if (ill) begin
            sel = ALU_NOP;
            d1  = '0;
            d2  = '0;
        end
    end

    assign sel_o     = sel;
    assign data1_o   = d1;
    assign data2_o   = d2;
    assign illegal_o = ill;

endmodule

// File: rtl/alu_issue.sv
// Issue/execute front end: decode into issue register s1 (drives the external ALU), capture ALU output in result register s2.
// Ports: in_* valid/ready input side, alu_* to/from the combinational ALU, res_* valid/ready result side. Latency 2 cycles.
// Full backpressure: in_ready is combinational from res_ready; accept and drain may coincide in both stages.
module alu_issue
    import alu_pkg::*;
#(
    parameter int WIDTH_DATA = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [31:0]           in_pc,
    input  logic [WIDTH_DATA-1:0] in_rs1_data,
    input  logic [WIDTH_DATA-1:0] in_rs2_data,
    output logic [WIDTH_DATA-1:0] alu_data1,
    output logic [WIDTH_DATA-1:0] alu_data2,
    output logic [3:0]            alu_select,
    input  logic [WIDTH_DATA-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH_DATA-1:0] res_data,
    output logic                  res_zero,
    output logic [4:0]            res_rd,
    output logic                  res_illegal
);

    alu_sel_e    dec_sel;
    logic [31:0] dec_data1;
    logic [31:0] dec_data2;
    logic [4:0]  dec_rd;
    logic        dec_illegal;

    alu_decode u_decode (
        .instr_i   (in_instr),
        .pc_i      (in_pc),
        .rs1_i     (in_rs1_data),
        .rs2_i     (in_rs2_data),
        .sel_o     (dec_sel),
        .data1_o   (dec_data1),
        .data2_o   (dec_data2),
        .rd_o      (dec_rd),
        .illegal_o (dec_illegal)
    );

    // Stage 1: issue register
    logic        s1_vld_q, s1_vld_d;
    logic [3:0]  s1_sel_q, s1_sel_d;
    logic [31:0] s1_data1_q, s1_data1_d;
    logic [31:0] s1_data2_q, s1_data2_d;
    logic [4:0]  s1_rd_q, s1_rd_d;
    logic        s1_ill_q, s1_ill_d;

    // Stage 2: result register
    logic        s2_vld_q, s2_vld_d;
    logic [31:0] s2_data_q, s2_data_d;
    logic        s2_zero_q, s2_zero_d;
    logic [4:0]  s2_rd_q, s2_rd_d;
    logic        s2_ill_q, s2_ill_d;

    logic s2_adv;
    logic s1_adv;

    assign s2_adv   = !s2_vld_q || res_ready;
    assign s1_adv   = !s1_vld_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_sel_d   = s1_sel_q;
        s1_data1_d = s1_data1_q;
        s1_data2_d = s1_data2_q;
        s1_rd_d    = s1_rd_q;
        s1_ill_d   = s1_ill_q;
        if (s1_adv) begin
            s1_vld_d = in_valid;
            // Payload only loads on a real accept; bubbles leave the ALU inputs quiet.
            if (in_valid) begin
                s1_sel_d   = dec_sel;
                s1_data1_d = dec_data1;
                s1_data2_d = dec_data2;
                s1_rd_d    = dec_rd;
                s1_ill_d   = dec_illegal;
            end
        end
    end

    always_comb begin
        s2_vld_d  = s2_vld_q;
        s2_data_d = s2_data_q;
        s2_zero_d = s2_zero_q;
        s2_rd_d   = s2_rd_q;
        s2_ill_d  = s2_ill_q;
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                // Illegal entries report a clean zero result regardless of the ALU.
                s2_data_d = s1_ill_q ? '0 : alu_result;
                s2_zero_d = s1_ill_q | alu_zero;
                s2_rd_d   = s1_rd_q;
                s2_ill_d  = s1_ill_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_sel_q   <= '0;
            s1_data1_q <= '0;
            s1_data2_q <= '0;
            s1_rd_q    <= '0;
            s1_ill_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_data_q  <= '0;
            s2_zero_q  <= 1'b0;
            s2_rd_q    <= '0;
            s2_ill_q   <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_sel_q   <= s1_sel_d;
            s1_data1_q <= s1_data1_d;
            s1_data2_q <= s1_data2_d;
            s1_rd_q    <= s1_rd_d;
            s1_ill_q   <= s1_ill_d;
            s2_vld_q   <= s2_vld_d;
            s2_data_q  <= s2_data_d;
            s2_zero_q  <= s2_zero_d;
            s2_rd_q    <= s2_rd_d;
            s2_ill_q   <= s2_ill_d;
        end
    end

    assign alu_select  = s1_sel_q;
    assign alu_data1   = s1_data1_q;
    assign alu_data2   = s1_data2_q;
    assign res_valid   = s2_vld_q;
    assign res_data    = s2_data_q;
    assign res_zero    = s2_zero_q;
    assign res_rd      = s2_rd_q;
    assign res_illegal = s2_ill_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU on the alu_* ports, instruction-level reference model and scoreboard.
// Directed cases then randomized traffic with random valid/ready; all comparisons through chk().
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [3:0]  alu_select;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_zero;
    logic [4:0]  res_rd;
    logic        res_illegal;

    always #5 clk = ~clk;

    alu_issue #(.WIDTH_DATA(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .alu_data1   (alu_data1),
        .alu_data2   (alu_data2),
        .alu_select  (alu_select),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_zero    (res_zero),
        .res_rd      (res_rd),
        .res_illegal (res_illegal)
    );

    // External combinational ALU as seen by the block.
    always_comb begin
        alu_result = 32'h0;
        case (alu_select)
            4'd1:  alu_result = alu_data1 + alu_data2;
            4'd2:  alu_result = alu_data1 - alu_data2;
            4'd3:  alu_result = alu_data1 << alu_data2[4:0];
            4'd4:  alu_result = {31'b0, $signed(alu_data1) < $signed(alu_data2)};
            4'd5:  alu_result = {31'b0, alu_data1 < alu_data2};
            4'd6:  alu_result = alu_data1 >> alu_data2[4:0];
            4'd7:  alu_result = $unsigned($signed(alu_data1) >>> alu_data2[4:0]);
            4'd8:  alu_result = alu_data1 ^ alu_data2;
            4'd9:  alu_result = alu_data1 | alu_data2;
            4'd10: alu_result = alu_data1 & alu_data2;
            4'd11: alu_result = alu_data2;
            4'd12: alu_result = alu_data1 + alu_data2;
            default: alu_result = 32'h0;
        endcase
    end
    assign alu_zero = (alu_result == 32'h0);

    typedef struct {
        logic [31:0] data;
        logic        zero;
        logic [4:0]  rd;
        logic        ill;
        int          acc;
        logic        stalled;
    } exp_t;

    exp_t        q[$];
    logic [31:0] pop_data[$];
    logic        pop_zero[$];
    logic        pop_ill[$];
    logic [4:0]  pop_rd[$];
    int          pop_cyc[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic last_acc;
    logic hold_pend = 1'b0;
    logic [31:0] hold_data;
    logic        hold_zero;
    logic [4:0]  hold_rd;
    logic        hold_ill;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Instruction semantics straight from the RV32I rules.
    function automatic exp_t ref_exec(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [4:0]  sh;
        op  = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        imm = {{20{ins[31]}}, ins[31:20]};
        sh  = ins[24:20];
        e.data = 32'h0;
        e.ill  = 1'b0;
        e.rd   = ins[11:7];
        e.acc  = 0;
        e.stalled = 1'b0;
        if (op == 7'b0110011) begin
            if (f7 == 7'h00) begin
                case (f3)
                    3'd0: e.data = a + b;
                    3'd1: e.data = a << b[4:0];
                    3'd2: e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: e.data = (a < b) ? 32'd1 : 32'd0;
                    3'd4: e.data = a ^ b;
                    3'd5: e.data = a >> b[4:0];
                    3'd6: e.data = a | b;
                    default: e.data = a & b;
                endcase
            end else if (f7 == 7'h20 && f3 == 3'd0) e.data = a - b;
            else if (f7 == 7'h20 && f3 == 3'd5) e.data = $unsigned($signed(a) >>> b[4:0]);
            else e.ill = 1'b1;
        end else if (op == 7'b0010011) begin
            case (f3)
                3'd0: e.data = a + imm;
                3'd2: e.data = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
                3'd3: e.data = (a < imm) ? 32'd1 : 32'd0;
                3'd4: e.data = a ^ imm;
                3'd6: e.data = a | imm;
                3'd7: e.data = a & imm;
                3'd1: if (f7 == 7'h00) e.data = a << sh; else e.ill = 1'b1;
                default: begin
                    if (f7 == 7'h00)      e.data = a >> sh;
                    else if (f7 == 7'h20) e.data = $unsigned($signed(a) >>> sh);
                    else                  e.ill = 1'b1;
                end
            endcase
        end else if (op == 7'b0110111) e.data = {ins[31:12], 12'b0};
        else if (op == 7'b0010111)     e.data = pc + {ins[31:12], 12'b0};
        else e.ill = 1'b1;
        if (e.ill) e.data = 32'h0;
        e.zero = (e.data == 32'h0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        int          r;
        w = $urandom;
        k = $urandom_range(0, 9);
        r = $urandom_range(0, 9);
        if (k <= 3) begin
            w[6:0] = 7'b0110011;
            w[31:25] = (r < 6) ? 7'h00 : (r < 9) ? 7'h20 : w[31:25];
        end else if (k <= 6) begin
            w[6:0] = 7'b0010011;
            if (w[13:12] == 2'b01) w[31:25] = (r < 6) ? 7'h00 : (r < 9) ? 7'h20 : w[31:25];
        end else if (k == 7) w[6:0] = 7'b0110111;
        else if (k == 8)     w[6:0] = 7'b0010111;
        return w;
    endfunction

    // One cycle: drive at negedge, settle, score the upcoming edge.
    task automatic tick(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b, input logic rr);
        exp_t e;
        @(negedge clk);
        in_valid = v; in_instr = ins; in_pc = pc; in_rs1_data = a; in_rs2_data = b; res_ready = rr;
        #1;
        cyc++;
        if (hold_pend) begin
            chk("hold_valid", {31'b0, res_valid}, 32'd1);
            chk("hold_data", res_data, hold_data);
            chk("hold_rd", {27'b0, res_rd}, {27'b0, hold_rd});
            chk("hold_flags", {30'b0, res_zero, res_illegal}, {30'b0, hold_zero, hold_ill});
        end
        chk("in_ready", {31'b0, in_ready}, (q.size() == 2 && !rr) ? 32'd0 : 32'd1);
        if (res_valid && res_ready) begin
            if (q.size() == 0) begin
                chk("spurious_result", {31'b0, res_valid}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("res_data", res_data, e.data);
                chk("res_zero", {31'b0, res_zero}, {31'b0, e.zero});
                chk("res_rd", {27'b0, res_rd}, {27'b0, e.rd});
                chk("res_illegal", {31'b0, res_illegal}, {31'b0, e.ill});
                if (!e.stalled) chk("latency", cyc - e.acc, 32'd2);
                pop_data.push_back(res_data); pop_zero.push_back(res_zero);
                pop_ill.push_back(res_illegal); pop_rd.push_back(res_rd); pop_cyc.push_back(cyc);
            end
        end
        if (res_valid && !rr)
            foreach (q[i]) q[i].stalled = 1'b1;
        hold_pend = res_valid && !rr;
        hold_data = res_data; hold_zero = res_zero; hold_rd = res_rd; hold_ill = res_illegal;
        last_acc = v && in_ready;
        if (last_acc) begin
            e = ref_exec(ins, pc, a, b);
            e.acc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic clear_log();
        pop_data.delete(); pop_zero.delete(); pop_ill.delete(); pop_rd.delete(); pop_cyc.delete();
    endtask

    initial begin
        int acc_cnt;
        int k;
        rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
        in_rs1_data = 32'h0; in_rs2_data = 32'h0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_flags", {30'b0, res_zero, res_illegal}, 32'd0);
        chk("rst_res_rd", {27'b0, res_rd}, 32'd0);
        chk("rst_alu_select", {28'b0, alu_select}, 32'd0);
        chk("rst_alu_data1", alu_data1, 32'd0);
        chk("rst_alu_data2", alu_data2, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // ADDI x1, x0, -1 with rs1 operand 5
        clear_log();
        tick(1'b1, 32'hFFF00093, 32'h0, 32'd5, 32'd0, 1'b1);
        idle(2);
        chk("addi_count", pop_data.size(), 32'd1);
        if (pop_data.size() == 1) begin
            chk("addi_data", pop_data[0], 32'h00000004);
            chk("addi_rd", {27'b0, pop_rd[0]}, 32'd1);
            chk("addi_zero", {31'b0, pop_zero[0]}, 32'd0);
        end

        // SUB x2, x1, x2
        clear_log();
        tick(1'b1, 32'h40208133, 32'h0, 32'h03800155, 32'h00055400, 1'b1);
        tick(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        chk("sub_select", {28'b0, alu_select}, 32'b0010);
        idle(1);
        chk("sub_count", pop_data.size(), 32'd1);
        if (pop_data.size() == 1) begin
            chk("sub_data", pop_data[0], 32'h037AAD55);
            chk("sub_rd", {27'b0, pop_rd[0]}, 32'd2);
        end

        // LUI then AUIPC back-to-back
        clear_log();
        tick(1'b1, 32'h123451B7, 32'h0, 32'h0, 32'h0, 1'b1);
        tick(1'b1, 32'h00001217, 32'h40, 32'h0, 32'h0, 1'b1);
        idle(2);
        chk("lui_auipc_count", pop_data.size(), 32'd2);
        if (pop_data.size() == 2) begin
            chk("lui_data", pop_data[0], 32'h12345000);
            chk("auipc_data", pop_data[1], 32'h00001040);
            chk("lui_auipc_spacing", pop_cyc[1] - pop_cyc[0], 32'd1);
        end

        // SRAI x5, x6, 4
        clear_log();
        tick(1'b1, 32'h40435293, 32'h0, 32'h83800155, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        chk("srai_select", {28'b0, alu_select}, 32'b0111);
        chk("srai_data2", alu_data2, 32'd4);
        idle(1);
        chk("srai_count", pop_data.size(), 32'd1);
        if (pop_data.size() == 1) begin
            chk("srai_data", pop_data[0], 32'hF8380015);
            chk("srai_rd", {27'b0, pop_rd[0]}, 32'd5);
        end

        // Backpressure: four ADDIs (rs1=100, imm=k+1, rd=k+1) with res_ready low for 4 cycles
        clear_log();
        k = 0;
        acc_cnt = 0;
        for (int t = 0; t < 30 && k < 4; t++) begin
            tick(1'b1, {12'(k + 1), 5'd3, 3'b000, 5'(k + 1), 7'b0010011}, 32'h0, 32'd100, 32'd0, t >= 4);
            if (last_acc) k++;
            if (t == 3) acc_cnt = k;
        end
        chk("bp_accepted_stalled", acc_cnt, 32'd2);
        chk("bp_all_accepted", k, 32'd4);
        for (int t = 0; t < 20 && q.size() != 0; t++) idle(1);
        chk("bp_count", pop_data.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < pop_data.size()) chk("bp_order", pop_data[i], 32'd101 + i);

        // ECALL is illegal
        clear_log();
        tick(1'b1, 32'h00000073, 32'h0, 32'h12345678, 32'h9, 1'b1);
        idle(2);
        chk("ecall_count", pop_data.size(), 32'd1);
        if (pop_data.size() == 1) begin
            chk("ecall_illegal", {31'b0, pop_ill[0]}, 32'd1);
            chk("ecall_data", pop_data[0], 32'd0);
            chk("ecall_zero", {31'b0, pop_zero[0]}, 32'd1);
        end

        // Reset with two entries in flight
        clear_log();
        tick(1'b1, 32'h00700093, 32'h0, 32'd1, 32'd0, 1'b0);
        tick(1'b1, 32'h00800113, 32'h0, 32'd2, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", {31'b0, res_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, res_valid}, 32'd0);
        chk("mid_rst_data", res_data, 32'd0);
        chk("mid_rst_select", {28'b0, alu_select}, 32'd0);
        q.delete();
        hold_pend = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        idle(4);
        chk("post_rst_no_result", pop_data.size(), 32'd0);

        // Randomized traffic
        for (int t = 0; t < 600; t++)
            tick(($urandom_range(0, 9) < 7), rand_instr(), $urandom, $urandom,
                 ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, ($urandom_range(0, 9) < 7));
        for (int t = 0; t < 20 && q.size() != 0; t++) idle(1);
        chk("drain_empty", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
